// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encodings and default line settings,
// kept in one place so a future transmitter can use the same values.
package uart_rx_pkg;

  localparam int UART_CLK_HZ  = 12_000_000;
  localparam int UART_BAUD    = 115_200;
  localparam int UART_MIN_CPB = 4;

  localparam logic [2:0] UART_IDLE  = 3'd0;
  localparam logic [2:0] UART_START = 3'd1;
  localparam logic [2:0] UART_DATA  = 3'd2;
  localparam logic [2:0] UART_STOP  = 3'd3;
  localparam logic [2:0] UART_BREAK = 3'd4;

  function automatic int uart_cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous input. Both flops reset
// to RESET_VAL so the synchronized output starts at the line's idle level.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its centre, delivers good bytes with
// a one-cycle strobe and flags bad stop bits with a separate strobe.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ = UART_CLK_HZ,
  parameter int BAUD   = UART_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       frame_error,
  output logic [2:0] dbg_state
);

  localparam int CPB  = uart_cpb(CLK_HZ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  generate
    if (CPB < UART_MIN_CPB) begin : g_cpb_check
      $error("uart_rx: CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

  logic          w_rx_s;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_received;
  logic          r_frame_err;

  sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  // r_cnt counts cycles within the current half/full bit; the sample is taken
  // on the edge where it reaches its last value, so it never exceeds CPB-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= UART_IDLE;
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_shift     <= 8'd0;
      r_byte      <= 8'd0;
      r_received  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_received  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        UART_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= UART_START;
          end
        end
        UART_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_state <= UART_IDLE;
            end else begin
              r_idx   <= 3'd0;
              r_state <= UART_DATA;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        UART_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= UART_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        UART_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            // Returning to IDLE at mid-stop lets the next start edge land
            // anywhere in the second half of this stop bit.
            if (w_rx_s) begin
              r_byte     <= r_shift;
              r_received <= 1'b1;
              r_state    <= UART_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= UART_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        UART_BREAK: begin
          r_cnt <= '0;
          if (w_rx_s) begin
            r_state <= UART_IDLE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= UART_IDLE;
        end
      endcase
    end
  end

  assign received    = r_received;
  assign rx_byte     = r_byte;
  assign frame_error = r_frame_err;
  assign dbg_state   = r_state;

endmodule
